// File: rtl/regfile_write_arbiter.sv
// Two-source writeback arbiter: per-source FIFOs feeding one registered register-file write port.
// Optional PENDING_QUERY_EN adds a combinational query_reg/query_hit in-flight lookup.
module regfile_write_arbiter #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [ADDR_W-1:0]          a_reg,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [ADDR_W-1:0]          b_reg,
  input  logic [DATA_W-1:0]          b_data,
`ifdef PENDING_QUERY_EN
  input  logic [ADDR_W-1:0]          query_reg,
  output logic                       query_hit,
`endif
  output logic                       reg_write,
  output logic [ADDR_W-1:0]          write_reg,
  output logic [DATA_W-1:0]          write_data,
  output logic [$clog2(DEPTH):0]     a_count,
  output logic [$clog2(DEPTH):0]     b_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {RR_A = 1'b0, RR_B = 1'b1} rr_t;

  logic [1:0]        in_valid;
  logic [1:0]        in_ready;
  logic [1:0]        nonempty;
  logic [1:0]        grant;
  logic [ADDR_W-1:0] in_reg   [2];
  logic [DATA_W-1:0] in_data  [2];
  logic [ADDR_W-1:0] head_reg [2];
  logic [DATA_W-1:0] head_data[2];
  logic [CNT_W-1:0]  count    [2];

  rr_t               rr_reg, rr_next;
  logic              reg_write_reg;
  logic [ADDR_W-1:0] write_reg_reg;
  logic [DATA_W-1:0] write_data_reg;

`ifdef PENDING_QUERY_EN
  logic [1:0]        src_hit;
`endif

  assign in_valid   = {b_valid, a_valid};
  assign in_reg[0]  = a_reg;
  assign in_reg[1]  = b_reg;
  assign in_data[0] = a_data;
  assign in_data[1] = b_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [ADDR_W-1:0] mem_reg_q  [DEPTH];
      logic [DATA_W-1:0] mem_data_q [DEPTH];
      logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
      logic [CNT_W-1:0]  count_reg, count_next;
      logic              push;

      assign in_ready[gi]  = (count_reg < DEPTH_C);
      assign nonempty[gi]  = (count_reg != '0);
      // Writes to r0 complete the handshake but are dropped here.
      assign push          = in_valid[gi] && in_ready[gi] && (in_reg[gi] != '0);
      assign head_reg[gi]  = mem_reg_q[rd_ptr_reg];
      assign head_data[gi] = mem_data_q[rd_ptr_reg];
      assign count[gi]     = count_reg;

      always_comb begin
        count_next = count_reg;
        case ({push, grant[gi]})
          2'b10:   count_next = count_reg + 1'b1;
          2'b01:   count_next = count_reg - 1'b1;
          default: count_next = count_reg;
        endcase
      end

      always_ff @(posedge clk) begin
        if (!rst) begin
          count_reg  <= '0;
          rd_ptr_reg <= '0;
          wr_ptr_reg <= '0;
        end else begin
          count_reg <= count_next;
          if (push)      wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (grant[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (push) begin
          mem_reg_q[wr_ptr_reg]  <= in_reg[gi];
          mem_data_q[wr_ptr_reg] <= in_data[gi];
        end
      end

`ifdef PENDING_QUERY_EN
      logic [DEPTH-1:0] ent_hit;
      genvar gj;
      for (gj = 0; gj < DEPTH; gj++) begin : g_ent
        logic [PTR_W-1:0] offset;
        // An entry is live when its distance from the read pointer is below the count.
        assign offset      = PTR_W'(gj) - rd_ptr_reg;
        assign ent_hit[gj] = ({1'b0, offset} < count_reg) && (mem_reg_q[gj] == query_reg);
      end
      assign src_hit[gi] = |ent_hit;
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) rr_reg <= RR_A;
    else      rr_reg <= rr_next;
  end

  always_comb begin
    grant   = 2'b00;
    rr_next = rr_reg;
    if (nonempty[0] && (!nonempty[1] || rr_reg == RR_A)) begin
      grant   = 2'b01;
      rr_next = RR_B;
    end else if (nonempty[1]) begin
      grant   = 2'b10;
      rr_next = RR_A;
    end
  end

  // Index/data hold their last value when idle; only the enable drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write_reg  <= 1'b0;
      write_reg_reg  <= '0;
      write_data_reg <= '0;
    end else begin
      reg_write_reg <= |grant;
      if (grant[0]) begin
        write_reg_reg  <= head_reg[0];
        write_data_reg <= head_data[0];
      end else if (grant[1]) begin
        write_reg_reg  <= head_reg[1];
        write_data_reg <= head_data[1];
      end
    end
  end

  assign a_ready    = in_ready[0];
  assign b_ready    = in_ready[1];
  assign a_count    = count[0];
  assign b_count    = count[1];
  assign reg_write  = reg_write_reg;
  assign write_reg  = write_reg_reg;
  assign write_data = write_data_reg;

`ifdef PENDING_QUERY_EN
  assign query_hit = (query_reg != '0) &&
                     ((|src_hit) || (reg_write_reg && (write_reg_reg == query_reg)));
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg = '0, b_reg = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [1:0]  a_count, b_count;
`ifdef PENDING_QUERY_EN
  logic [4:0]  query_reg = '0;
  logic        query_hit;
`endif

  regfile_write_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
`ifdef PENDING_QUERY_EN
    .query_reg(query_reg), .query_hit(query_hit),
`endif
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: FIFOs as queues, the write port as three plain variables.
  typedef struct packed { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        qa[$], qb[$];
  bit          prefer_b;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic [4:0]  wr_log[$];

  task automatic model_edge();
    bit acc_a, acc_b, give_a, give_b;
    ent_t h;
    if (!rst) begin
      qa.delete(); qb.delete();
      prefer_b = 0; m_we = 0; m_reg = '0; m_data = '0;
    end else begin
      acc_a  = a_valid && (qa.size() < DEPTH);
      acc_b  = b_valid && (qb.size() < DEPTH);
      give_a = (qa.size() > 0) && ((qb.size() == 0) || !prefer_b);
      give_b = !give_a && (qb.size() > 0);
      m_we   = give_a || give_b;
      if (give_a) begin h = qa.pop_front(); m_reg = h.r; m_data = h.d; prefer_b = 1; end
      if (give_b) begin h = qb.pop_front(); m_reg = h.r; m_data = h.d; prefer_b = 0; end
      if (acc_a && a_reg != 0) qa.push_back('{a_reg, a_data});
      if (acc_b && b_reg != 0) qb.push_back('{b_reg, b_data});
    end
  endtask

  function automatic bit model_hit(input logic [4:0] q);
    bit hit = 0;
    if (q == 0) return 0;
    foreach (qa[i]) if (qa[i].r == q) hit = 1;
    foreach (qb[i]) if (qb[i].r == q) hit = 1;
    if (m_we && m_reg == q) hit = 1;
    return hit;
  endfunction

  task automatic compare_all();
    check("reg_write",  64'(reg_write),  64'(m_we));
    check("write_reg",  64'(write_reg),  64'(m_reg));
    check("write_data", 64'(write_data), 64'(m_data));
    check("a_count",    64'(a_count),    64'(qa.size()));
    check("b_count",    64'(b_count),    64'(qb.size()));
    check("a_ready",    64'(a_ready),    64'(qa.size() < DEPTH));
    check("b_ready",    64'(b_ready),    64'(qb.size() < DEPTH));
`ifdef PENDING_QUERY_EN
    query_reg = 5'($urandom_range(0, 7));
    #1;
    check("query_hit",  64'(query_hit),  64'(model_hit(query_reg)));
`endif
    if (reg_write) begin
      wr_log.push_back(write_reg);
      $display("write reg %0d data %08h", write_reg, write_data);
    end
  endtask

  task automatic step(input bit r, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit bv, input logic [4:0] br, input logic [31:0] bd);
    rst = r; a_valid = av; a_reg = ar; a_data = ad; b_valid = bv; b_reg = br; b_data = bd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both sources offering
    step(0, 1, 3, 32'h1, 1, 4, 32'h2);
    step(0, 1, 3, 32'h1, 1, 4, 32'h2);
    check("rst_reg_write", 64'(reg_write), 64'd0);
    check("rst_write_reg", 64'(write_reg), 64'd0);
    check("rst_write_data", 64'(write_data), 64'd0);
    check("rst_counts", 64'({a_count, b_count}), 64'd0);
    idle();
    check("post_rst_no_write", 64'(reg_write), 64'd0);

    // Single write latency
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("single_not_early", 64'(reg_write), 64'd0);
    idle();
    check("single_we", 64'(reg_write), 64'd1);
    check("single_reg", 64'(write_reg), 64'd5);
    check("single_data", 64'(write_data), 64'hDEADBEEF);
    idle();
    check("single_one_cycle", 64'(reg_write), 64'd0);

    // Contention straight after reset: A wins first, then alternation
    step(0, 0, 0, 0, 0, 0, 0);
    wr_log.delete();
    step(1, 1, 1, 32'h11, 1, 3, 32'h33);
    step(1, 1, 2, 32'h22, 1, 4, 32'h44);
    for (int i = 0; i < 4; i++) idle();
    check("order_len", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) begin
      check("order_0", 64'(wr_log[0]), 64'd1);
      check("order_1", 64'(wr_log[1]), 64'd3);
      check("order_2", 64'(wr_log[2]), 64'd2);
      check("order_3", 64'(wr_log[3]), 64'd4);
    end
    check("order_idle", 64'(reg_write), 64'd0);

    // Register 0 filter
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 32'hFFFF, 0, 0, 0);
      check("r0_ready", 64'(a_ready), 64'd1);
      check("r0_count", 64'(a_count), 64'd0);
    end
    idle();
    check("r0_no_write", 64'(reg_write), 64'd0);

    // Sustained pressure on both sources
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 5'(1 + i % 7), $urandom, 1, 5'(9 + i % 5), $urandom);
      check("b_count_bound", 64'(b_count <= 2'(DEPTH)), 64'd1);
    end

`ifdef PENDING_QUERY_EN
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 7, 32'h77, 0, 0, 0);
    query_reg = 7; #1;
    check("q_queued", 64'(query_hit), 64'd1);
    query_reg = 0; #1;
    check("q_zero", 64'(query_hit), 64'd0);
    idle();
    query_reg = 7; #1;
    check("q_on_port", 64'(query_hit), 64'd1);
    idle();
    query_reg = 7; #1;
    check("q_retired", 64'(query_hit), 64'd0);
`endif

    // Random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
